imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction-memory read interface: takes a byte stream from a host or boot source and packs it into 32-bit little-endian words.
- Writes those words into the instruction memory write port while holding the core stalled.
- Sits between the external boot/debug link and the instruction file, alongside the core top level.
- Releases the core only after a complete, error-free load.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words (power of two, >= 2).
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word (word aligned).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- s_valid  input  1  stream byte valid
- s_data  input  8  stream byte
- s_last  input  1  marks the final byte of the program, qualified by s_valid
- s_ready  output  1  loader accepts the byte this cycle; transfer occurs when s_valid and s_ready are both 1
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  32  byte address = BASE_ADDR + 4*word_index
- imem_wdata  output  32  packed word; byte 0 at [7:0]
- core_hold  output  1  stall/hold request to the core (1 = core frozen)
- done  output  1  sticky, load completed
- error  output  1  sticky, load aborted
- words_loaded  output  $clog2(DEPTH_WORDS)+1  count of words written in the current or last load

Behaviour:
- Reset (async, rst_n=0) values: state=IDLE, s_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_hold=1, done=0, error=0, words_loaded=0, byte index=0.
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start → LOAD next cycle; clear done, error, words_loaded, byte index and word buffer; core_hold=1. start in LOAD/WRITE is ignored.
- LOAD: s_ready=1. Each accepted byte goes to buffer lane [8*idx +: 8] and idx increments.
- LOAD → WRITE on the accepted byte with idx==3, or on any accepted byte with s_last=1.
- WRITE lasts exactly one cycle:
  - s_ready=0, imem_we=1, imem_addr=BASE_ADDR+4*words_loaded, imem_wdata=buffer.
  - Unfilled upper lanes of a short final word are 0.
  - words_loaded increments at the end of the cycle; buffer and idx are cleared.
  - Then → DONE if the word contained s_last, else → LOAD.
- Latency: imem_we asserts in the cycle after the 4th (or last) byte is accepted. Peak rate is 4 bytes per 5 cycles.
- DONE: core_hold=0, done=1, s_ready=0, imem_we=0.
- Overflow: a byte accepted in LOAD while words_loaded==DEPTH_WORDS → ERR. That byte is discarded and nothing is written.
- ERR: core_hold=1, error=1, s_ready=0. The core stays frozen until a new successful load.
- IDLE: core_hold=1 (no program loaded yet), s_ready=0.
- imem_addr/imem_wdata hold their last values when imem_we=0.
- rst_n asserted mid-load: immediate return to reset values. The partial buffer is lost; memory already written is not touched.
- s_valid with s_ready=0 has no effect; bytes are never dropped silently except in the overflow case.

Optional Feature:
- Macro IMEM_LOADER_CKSUM_EN.
- Defined:
  - Keeps an 8-bit running sum (mod 256) of all data bytes in the load.
  - The byte carrying s_last is the checksum, not program data.
  - On its acceptance: if idx>0, the partial word is written via WRITE first; if idx==0, no write.
  - Then → DONE if checksum == running sum, else → ERR.
  - Extra output cksum_calc[7:0] shows the running sum; reset value 0, cleared on start.
- Undefined: the s_last byte is ordinary data, no cksum_calc port, and no checksum-driven ERR.

Test Plan:
- Reset release then start, stream 13 00 00 00 93 00 10 00 (last on 8th byte) → two writes: addr 0x0 data 0x00000013, addr 0x4 data 0x00100093. Then done=1, core_hold=0, words_loaded=2.
- Stream 5 bytes AA BB CC DD 11(last) → writes 0xDDCCBBAA @0x0, then 0x00000011 @0x4. done=1.
- Random s_valid gaps (50% duty) over 64 bytes → 16 writes, in order, with correct data. Each imem_we is exactly 1 cycle wide with s_ready=0 in that cycle.
- DEPTH_WORDS=4, stream 17 bytes → 4 writes, then ERR on byte 17. error=1, core_hold=1, no 5th write. A following start plus a valid 4-byte load → done=1.
- rst_n pulsed low after 6 bytes accepted → all outputs at reset values immediately. After start, the load restarts at addr BASE_ADDR.
- With IMEM_LOADER_CKSUM_EN: bytes 01 02 03 then checksum 06(last) → one write 0x00030201, done=1. Repeat with checksum 07 → same write, then error=1, core_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// imem_loader: packs a byte stream into 32-bit little-endian words and writes them into
// instruction memory while holding the core. Optional checksum trailer: IMEM_LOADER_CKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         s_valid,
  input  logic [7:0]                   s_data,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic                         imem_we,
  output logic [31:0]                  imem_addr,
  output logic [31:0]                  imem_wdata,
  output logic                         core_hold,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(DEPTH_WORDS):0] words_loaded
`ifdef IMEM_LOADER_CKSUM_EN
  ,
  output logic [7:0]                   cksum_calc
`endif
);

  localparam int unsigned CW = $clog2(DEPTH_WORDS) + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  logic [2:0]  state;
  logic [1:0]  idx;
  logic [31:0] buffer;
  logic        last_word;
  logic        full;
  logic        overflow;
  logic [31:0] merged;
  logic [31:0] next_addr;

  assign full      = (words_loaded == CW'(DEPTH_WORDS));
  assign merged    = buffer | ({24'd0, s_data} << {idx, 3'b000});
  assign next_addr = BASE_ADDR + 32'({words_loaded, 2'b00});

  assign s_ready   = (state == ST_LOAD);
  assign imem_we   = (state == ST_WRITE);
  assign core_hold = (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign error     = (state == ST_ERR);

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] sum;
  logic       cksum_ok;

  // A checksum trailer arriving on a word boundary writes nothing, so it cannot overflow.
  assign overflow   = full && !(s_last && (idx == 2'd0));
  assign cksum_calc = sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 8'd0;
    end else if ((state == ST_IDLE || state == ST_DONE || state == ST_ERR) && start) begin
      sum <= 8'd0;
    end else if (state == ST_LOAD && s_valid && !overflow && !s_last) begin
      sum <= sum + s_data;
    end
  end
`else
  assign overflow = full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= 2'd0;
      buffer       <= 32'd0;
      last_word    <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 32'd0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_ok     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_LOAD;
            idx          <= 2'd0;
            buffer       <= 32'd0;
            last_word    <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_ok     <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            if (overflow) begin
              state <= ST_ERR;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            else if (s_last) begin
              cksum_ok <= (s_data == sum);
              if (idx != 2'd0) begin
                imem_addr  <= next_addr;
                imem_wdata <= buffer;
                last_word  <= 1'b1;
                state      <= ST_WRITE;
              end else begin
                state <= (s_data == sum) ? ST_DONE : ST_ERR;
              end
            end
`endif
            else if (s_last || idx == 2'd3) begin
              imem_addr  <= next_addr;
              imem_wdata <= merged;
              last_word  <= s_last;
              state      <= ST_WRITE;
            end else begin
              buffer <= merged;
              idx    <= idx + 2'd1;
            end
          end
        end
        ST_WRITE: begin
          words_loaded <= words_loaded + CW'(1);
          buffer       <= 32'd0;
          idx          <= 2'd0;
          if (!last_word) begin
            state <= ST_LOAD;
          end else begin
`ifdef IMEM_LOADER_CKSUM_EN
            state <= cksum_ok ? ST_DONE : ST_ERR;
`else
            state <= ST_DONE;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
